layer0_weight_rx: RTL
=====================

Name: layer0_weight_rx

Overview:
- Receiving end of the layer-0 weight stream: 64-bit valid/ready/last beats, 8 signed weight bytes per beat, byte 0 in bits [7:0].
- Captures one full kernel set into an internal 144x64 buffer: 1152 bytes = 32 out-ch x 4 in-ch x 9 taps.
- Checks framing against `weight_last`.
- Exposes a 1-cycle-latency read port that the layer-0 conv engine uses to fetch weight words.

Parameters:
- DATA_W, 64, stream and buffer word width (bits).
- BEATS, 144, beats per complete weight frame.
- ADDR_W, 8, width of beat counter and read address (must hold BEATS).

Ports:
- sclk  in  1  system clock, all logic on rising edge.
- s_rst  in  1  synchronous active-high reset.
- load_start  in  1  single-cycle pulse: arm (or re-arm) reception of a new frame.
- weight_data  in  DATA_W  stream payload.
- weight_valid  in  1  payload valid.
- weight_last  in  1  marks the final beat of the frame.
- weight_ready  out  1  receiver can accept a beat.
- load_done  out  1  complete, correctly framed set is held in the buffer.
- load_err  out  1  framing error detected; sticky until load_start or reset.
- beat_cnt  out  ADDR_W  beats accepted in the current frame.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  word address 0..BEATS-1.
- rd_data  out  DATA_W  read word.
- rd_valid  out  1  rd_data valid.

Behaviour:
- Reset (s_rst=1 at a clock edge):
  - state=IDLE.
  - weight_ready=0, load_done=0, load_err=0, beat_cnt=0, rd_valid=0, rd_data=0.
  - Buffer contents are not cleared.
- Beat acceptance:
  - A beat is accepted when weight_valid && weight_ready at a rising edge.
  - weight_ready is combinational: (state==RECV) && !load_start.
  - Data is never dropped while weight_ready=1.
- FSM states: IDLE, RECV, DONE, ERR.
  - IDLE -> RECV on load_start.
  - RECV, accepted beat: write weight_data to buffer[beat_cnt]; beat_cnt++.
  - RECV -> DONE when the accepted beat has beat_cnt==BEATS-1 and weight_last=1.
  - RECV -> ERR when an accepted beat has weight_last=1 and beat_cnt<BEATS-1 (early last).
  - RECV -> ERR when an accepted beat has beat_cnt==BEATS-1 and weight_last=0 (missing last).
  - In both ERR cases the beat is still written.
  - DONE: load_done=1, weight_ready=0.
  - ERR: load_err=1, weight_ready=0.
- load_start in any state:
  - Next state is RECV; beat_cnt, load_done and load_err are cleared.
  - load_start has priority over a coincident beat. weight_ready is 0 that cycle, so no beat is accepted.
- Flags are registered: load_done and load_err rise the cycle after the terminating beat, and beat_cnt shows BEATS (144) at that point. beat_cnt holds its value in DONE and ERR.
- Read port:
  - On rd_en, rd_data is registered the next cycle and rd_valid=1 for exactly one cycle.
  - rd_en is honoured in any state; data reflects current buffer contents.
  - rd_addr>=BEATS returns rd_data=0 with rd_valid=1.
  - A read and write to the same address in the same cycle return the old data (read-before-write).
- Back-to-back rd_en gives a new word every cycle.

Decomposition:
- Shared package layer0_pkg:
  - L0_WEIGHT_BEATS=144, L0_WEIGHT_W=64, L0_OUT_CH=32, L0_IN_CH=4, L0_TAPS=9.
  - FSM state typedef {IDLE, RECV, DONE, ERR}.
- One sub-module is natural: weight_buf_sdp, a simple dual-port RAM (1 write port, 1 registered read port, DEPTH/WIDTH parameters). It maps to BRAM; FSM, counter and framing checks stay in the top.

Test Plan:
- Normal load: reset, load_start, 144 beats with weight_valid held high, byte k=k[7:0], last on beat 143 -> weight_ready 1 for 144 cycles; load_done=1 the next cycle; load_err=0; beat_cnt=144; reading addr 0 returns 0x0706050403020100 and addr 143 returns 0x7F7E7D7C7B7A7978, each with rd_valid 1 cycle later.
- Backpressure/gaps: weight_valid toggled randomly across 144 beats -> exactly 144 accepted; buffer identical to the normal-load case; load_done after the last handshake.
- Early last: weight_last asserted on beat 99 -> load_err=1 the next cycle; beat_cnt=100; weight_ready=0; load_done=0; further valid beats not accepted.
- Missing last: 144 beats with weight_last=0 -> load_err=1 after beat 143; load_done stays 0.
- Restart: load_start mid-frame at beat_cnt=50, coincident with weight_valid=1 -> that beat is not accepted (weight_ready=0); beat_cnt=0 next cycle; a following full frame completes with load_done=1.
- Reset mid-frame and out-of-range read: s_rst at beat 70 -> all outputs return to reset values next cycle and weight_ready=0 until load_start; rd_en with rd_addr=200 -> rd_data=0, rd_valid=1.

Source files
------------

// File: rtl/layer0_pkg.sv
// layer0_pkg: shared layer-0 geometry and weight-receiver FSM states.
package layer0_pkg;
    localparam int L0_OUT_CH = 32;
    localparam int L0_IN_CH = 4;
    localparam int L0_TAPS = 9;
    localparam int L0_WEIGHT_W = 64;
    localparam int L0_WEIGHT_BEATS = L0_OUT_CH * L0_IN_CH * L0_TAPS * 8 / L0_WEIGHT_W;
    typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} l0_rx_state_t;
endpackage

// File: rtl/weight_buf_sdp.sv
// weight_buf_sdp: simple dual-port RAM, one write port and one registered read port.
module weight_buf_sdp #(
    parameter int DEPTH = 144,
    parameter int WIDTH = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // Out-of-range addresses read as zero but still complete with rd_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= (raddr < ADDR_W'(DEPTH)) ? mem[raddr] : '0;
        end
    end
endmodule

// File: rtl/layer0_weight_rx.sv
// layer0_weight_rx: captures one framed layer-0 weight set into a buffer and
// serves it to the conv engine through a 1-cycle read port.
module layer0_weight_rx
    import layer0_pkg::*;
#(
    parameter int DATA_W = L0_WEIGHT_W,
    parameter int BEATS = L0_WEIGHT_BEATS,
    parameter int ADDR_W = 8
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              load_start,
    input  logic [DATA_W-1:0] weight_data,
    input  logic              weight_valid,
    input  logic              weight_last,
    output logic              weight_ready,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] beat_cnt,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    l0_rx_state_t state, state_n;
    logic [ADDR_W-1:0] cnt_n;
    logic accept, at_end;
    assign weight_ready = (state == RECV) && !load_start;
    assign accept = weight_valid && weight_ready;
    assign at_end = beat_cnt == ADDR_W'(BEATS - 1);
    assign load_done = state == DONE;
    assign load_err = state == ERR;
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state <= IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_n;
            beat_cnt <= cnt_n;
        end
    end
    // A frame ends on whichever comes first: last flag or final beat; only both together is clean.
    always_comb begin
        state_n = load_start ? RECV
                : (accept && (weight_last || at_end)) ? ((weight_last && at_end) ? DONE : ERR)
                : state;
        cnt_n = load_start ? '0 : accept ? beat_cnt + 1'b1 : beat_cnt;
    end
    weight_buf_sdp #(.DEPTH(BEATS), .WIDTH(DATA_W), .ADDR_W(ADDR_W)) u_buf (
        .clk(sclk),
        .rst(s_rst),
        .we(accept),
        .waddr(beat_cnt),
        .wdata(weight_data),
        .rd_en(rd_en),
        .raddr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid)
    );
endmodule
